// File: rtl/demux1x2_32bits_buf.sv
// demux1x2_32bits_buf: routes one valid/ready input stream to one of two
// buffered output channels (A for in_sel=0, B for in_sel=1).
// Each channel owns a DEPTH-entry FIFO with registered storage and no bypass.
// Optional build macro DEMUX_XFER_COUNT_EN adds per-channel pop counters
// a_count / b_count (CW bits, wrapping).

module demux1x2_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             pop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;

    // Status flags and the head word, all derived from registered state
    always_comb begin
        valid = (cnt != '0);
        full  = (cnt == FULL_CNT);
        pop   = valid & ready;
        rdata = mem[rptr];
    end

    // Storage array; cleared on reset so the head word reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

module demux1x2_32bits_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             a_valid,
    output logic [WIDTH-1:0] a_data,
    input  logic             a_ready,
    output logic             b_valid,
    output logic [WIDTH-1:0] b_data,
    input  logic             b_ready,
`ifdef DEMUX_XFER_COUNT_EN
    output logic [CW-1:0]    a_count,
    output logic [CW-1:0]    b_count,
`endif
    output logic             busy
);

    logic a_full;
    logic b_full;
    logic a_push;
    logic b_push;
    logic a_pop;
    logic b_pop;

    // Ready reflects only the selected channel's fullness, never the valids/readies
    always_comb begin
        in_ready = in_sel ? ~b_full : ~a_full;
        a_push   = in_valid & in_ready & ~in_sel;
        b_push   = in_valid & in_ready &  in_sel;
        busy     = a_valid | b_valid;
    end

    demux1x2_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (a_push),
        .wdata (in_data),
        .ready (a_ready),
        .valid (a_valid),
        .rdata (a_data),
        .full  (a_full),
        .pop   (a_pop)
    );

    demux1x2_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (b_push),
        .wdata (in_data),
        .ready (b_ready),
        .valid (b_valid),
        .rdata (b_data),
        .full  (b_full),
        .pop   (b_pop)
    );

`ifdef DEMUX_XFER_COUNT_EN
    // Completed-pop counters, wrapping at 2^CW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_pop) begin
                a_count <= a_count + 1'b1;
            end
            if (b_pop) begin
                b_count <= b_count + 1'b1;
            end
        end
    end
`else
    logic unused_pops;
    always_comb unused_pops = a_pop | b_pop;
`endif

endmodule

// File: tb/tb_demux1x2_32bits_buf.sv
// Scoreboard bench for demux1x2_32bits_buf: the driver records accepted words
// into per-channel expected queues; a negedge monitor compares DUT outputs to
// the queue heads and retires entries on each modelled pop.
`timescale 1ns/1ps

module tb_demux1x2_32bits_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sel = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready = 1'b0;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready = 1'b0;
    logic             busy;
`ifdef DEMUX_XFER_COUNT_EN
    logic [CW-1:0]    a_count;
    logic [CW-1:0]    b_count;
`endif

    demux1x2_32bits_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .in_ready (in_ready),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_ready  (b_ready),
`ifdef DEMUX_XFER_COUNT_EN
        .a_count  (a_count),
        .b_count  (b_count),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    int errors = 0;
    int checks = 0;
    int accepted = 0;
    int unsigned pops_a = 0;
    int unsigned pops_b = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare outputs with the model, then retire modelled pops
    always @(negedge clk) begin
        logic exp_ready;
        exp_ready = in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        chk("a_valid", {31'd0, a_valid}, {31'd0, qa.size() != 0});
        chk("b_valid", {31'd0, b_valid}, {31'd0, qb.size() != 0});
        chk("busy", {31'd0, busy}, {31'd0, (qa.size() + qb.size()) != 0});
        if (qa.size() != 0) chk("a_data", a_data, qa[0]);
        if (qb.size() != 0) chk("b_data", b_data, qb[0]);
`ifdef DEMUX_XFER_COUNT_EN
        chk("a_count", {16'd0, a_count}, {16'd0, pops_a[CW-1:0]});
        chk("b_count", {16'd0, b_count}, {16'd0, pops_b[CW-1:0]});
`endif
        if (rst_n && a_ready && qa.size() != 0) begin
            void'(qa.pop_front());
            pops_a++;
        end
        if (rst_n && b_ready && qb.size() != 0) begin
            void'(qb.pop_front());
            pops_b++;
        end
    end

    // Drive one cycle of inputs, then record an accepted word as expected output
    task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic ar, input logic br);
        @(posedge clk);
        #1;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        @(negedge clk);
        #1;
        if (rst_n && in_valid && in_ready) begin
            if (in_sel) qb.push_back(in_data);
            else        qa.push_back(in_data);
            accepted++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        qa.delete();
        qb.delete();
        pops_a = 0;
        pops_b = 0;
        #1;
        chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_a_data", a_data, 32'd0);
        chk("rst_b_data", b_data, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("drain_a_empty", 32'(qa.size()), 32'd0);
        chk("drain_b_empty", 32'(qb.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int cyc;
        // Reset state (first reset has nothing buffered)
        do_reset();

        // Basic routing
        step(1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1);
        drain();

        // Full A with backpressure; B still accepts; then ordered drain of A
        step(1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hBAD, 1'b0, 1'b0);
        chk("full_no_push", 32'(qa.size()), 32'd2);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        drain();

        // Simultaneous push and pop on A at count 1
        step(1'b1, 1'b0, 32'h0BADF00D, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0);
        chk("pushpop_count", 32'(qa.size()), 32'd1);
        chk("pushpop_head", qa[0], 32'hA5A5A5A5);
        drain();

        // Reset mid-stream with both channels holding data
        step(1'b1, 1'b0, 32'h11, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h22, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h33, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h55, 1'b0, 1'b1);
        drain();

        // Random stress: 1000 accepted words
        do_reset();
        start = accepted;
        cyc = 0;
        while ((accepted - start) < 1000 && cyc < 20000) begin
            step(($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), $urandom(),
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            cyc++;
        end
        chk("stress_accepted", 32'(accepted - start), 32'd1000);
        drain();
        chk("stress_pops", pops_a + pops_b, 32'd1000);
`ifdef DEMUX_XFER_COUNT_EN
        chk("stress_count_sum", 32'(a_count) + 32'(b_count), 32'd1000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux1x2_32bits_buf.md
Name: demux1x2_32bits_buf

Overview:
- Inverse of the 2-to-1 32-bit datapath select: routes one 32-bit input stream to one of two output channels (A for sel=0, B for sel=1).
- Each output channel holds a small FIFO, so a stalled channel does not corrupt data already routed.
- Sits between a single producer (e.g. ALU result bus) and two independent consumers, using valid/ready handshakes on all sides.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.
- CW, 16, width of the optional per-channel transfer counters.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer presents a word.
- in_sel  input  1  destination for the word: 0 = channel A, 1 = channel B.
- in_data  input  WIDTH  input word.
- in_ready  output  1  word accepted this cycle when in_valid & in_ready.
- a_valid  output  1  channel A FIFO not empty.
- a_data  output  WIDTH  channel A head word.
- a_ready  input  1  consumer A pops the head word when a_valid & a_ready.
- b_valid  output  1  channel B FIFO not empty.
- b_data  output  WIDTH  channel B head word.
- b_ready  input  1  consumer B pops the head word when b_valid & b_ready.
- busy  output  1  either FIFO non-empty.

Behaviour:
- Reset (rst_n=0, asynchronous) clears:
  - FIFO read/write pointers and occupancy counts to 0.
  - a_valid, b_valid and busy to 0.
  - a_data and b_data to 0 (storage array cleared).
- Releasing reset mid-operation discards all buffered words; none reappear.
- Handshake rules:
  - in_ready = NOT full(selected FIFO), combinational from in_sel and the occupancy registers.
  - in_ready must not depend on in_valid, a_ready or b_ready.
- Push:
  - On an accepted transfer, in_data is written at the selected FIFO's write pointer.
  - Write pointer increments modulo DEPTH; count increments.
- Pop:
  - When x_valid & x_ready, the read pointer increments modulo DEPTH; count decrements.
  - x_data always shows the entry at the read pointer (registered storage, no combinational path from in_data).
- Latency: a word accepted at edge N appears on x_valid/x_data after edge N; the FIFO has no same-cycle bypass.
- Simultaneous push and pop on the same channel:
  - Not full: count unchanged, both pointers advance.
  - Full: no push (in_ready=0 for that channel); the pop proceeds.
  - Full channels accept a new word no earlier than the cycle after a pop.
- Simultaneous pop on A and push to B (or the reverse): independent, both occur.
- Empty FIFO: x_valid=0; x_ready is ignored; the pointer does not move.
- Full FIFO: count equals DEPTH; a push attempt leaves state unchanged and in_ready stays 0.
- Ordering:
  - Strict FIFO order per channel.
  - No ordering guarantee between A and B.
- in_sel is sampled only on an accepted transfer; changes while in_valid=0 have no effect.
- A producer stalled on a full channel may change in_sel; in_ready follows the new selection in the same cycle.
- busy = a_valid | b_valid.

Optional Feature:
- Macro: DEMUX_XFER_COUNT_EN.
- When defined, the block adds outputs a_count and b_count, each CW bits.
  - Each increments by 1 per completed pop on its channel.
  - Both wrap from 2^CW-1 to 0.
  - Both reset to 0 on rst_n.
- When undefined:
  - The ports and counters do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 with both FIFOs holding data -> a_valid=b_valid=busy=0 and a_data=b_data=0 immediately (asynchronous); after release, no stale word appears.
- Basic routing: push 0xDEADBEEF sel=0, then 0x12345678 sel=1, both readies high -> A delivers 0xDEADBEEF one cycle after accept, B delivers 0x12345678; no cross-channel leakage.
- Full/backpressure: a_ready=0, push 0x1, 0x2 to A (DEPTH=2) -> in_ready=0 for sel=0 while in_ready=1 for sel=1; a push of 0x3 to B still succeeds; raise a_ready -> 0x1 then 0x2 in order.
- Simultaneous push/pop on A at count 1: push 0xA5A5A5A5 while popping -> count stays 1, next head = 0xA5A5A5A5.
- Random stress: 1000 words with random sel and random a_ready/b_ready -> per-channel scoreboard matches exactly; a_count + b_count = 1000 when DEMUX_XFER_COUNT_EN is defined.
- Reset mid-stream: assert rst_n after 3 accepted words -> all state cleared; a fresh push of 0x55 to B is the first word out of B.
